exact_divider_16by8: RTL and testbench

Sequential radix-2 restoring divider: 16-bit dividend ÷ 8-bit divisor → 8-bit quotient and 8-bit remainder.

- It is the inverse datapath of the 8×8 multipliers: it reconstructs an operand from a product and the other operand.
- It is the golden reference for error measurement of the approximate multipliers in the same design.
- Valid/ready handshakes on both sides.
- One quotient bit per cycle.
- Divide-by-zero and quotient overflow are flagged.

---
 rtl/divider_pkg.sv | 16 +
 rtl/div_step.sv | 31 +++
 rtl/exact_divider_16by8.sv | 109 ++++++++++
 tb/tb_exact_divider_16by8.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM states, default width
// and the saturation pattern reported on divide-by-zero or overflow.
package divider_pkg;

  localparam int DIV_DW = 8;

  // Wide enough for any practical DW; the top slices off what it needs.
  localparam logic [63:0] DIV_SAT_ALL = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module div_step
  import divider_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic [DW:0]   r,
  input  logic          next_bit,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   r_next,
  output logic          q_bit
);

  logic [DW+1:0] r_shift;
  logic [DW:0]   diff;

  assign r_shift = {r, next_bit};
  assign diff    = r_shift[DW:0] - {1'b0, divisor};

  // Keep the difference when the divisor fits, otherwise restore the shifted value.
  always_comb begin
    q_bit  = 1'b0;
    r_next = r_shift[DW:0];
    if (r_shift >= {2'b00, divisor}) begin
      q_bit  = 1'b1;
      r_next = diff;
    end
  end

endmodule

// File: rtl/exact_divider_16by8.sv
// Sequential radix-2 restoring divider, 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module exact_divider_16by8
  import divider_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = $clog2(DW);

  state_t        state;
  logic [DW:0]   r;
  logic [DW-1:0] dvs;
  logic [DW-1:0] dvd_lo;
  logic [CW-1:0] cnt;
  logic [DW:0]   r_next;
  logic          q_bit;

  assign in_ready = (state == IDLE);

  div_step #(.DW(DW)) u_step (
    .r        (r),
    .next_bit (dvd_lo[DW-1]),
    .divisor  (dvs),
    .r_next   (r_next),
    .q_bit    (q_bit)
  );

  // Control FSM and datapath; the quotient register doubles as the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      dvs         <= '0;
      dvd_lo      <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvs    <= divisor;
            dvd_lo <= dividend[DW-1:0];
            r      <= {1'b0, dividend[2*DW-1:DW]};
            cnt    <= CW'(DW - 1);
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= DIV_SAT_ALL[DW-1:0];
              remainder   <= dividend[DW-1:0];
              state       <= DONE;
            end else if (dividend[2*DW-1:DW] >= divisor) begin
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= DIV_SAT_ALL[DW-1:0];
              remainder   <= dividend[DW-1:0];
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          r        <= r_next;
          dvd_lo   <= {dvd_lo[DW-2:0], 1'b0};
          quotient <= {quotient[DW-2:0], q_bit};
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            remainder <= r_next[DW-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Error results enter DONE with out_valid low and publish one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exact_divider_16by8.sv
// Self-checking bench for exact_divider_16by8: a scoreboard holds the
// expected result of every accepted op and is checked on each output handshake.
module tb_exact_divider_16by8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle_count  = 0;

  exact_divider_16by8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to measure accept spacing.
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Reference model built from plain integer division.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t        e;
    int unsigned qa;
    int unsigned ra;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (b == 8'd0) begin
      e.dz = 1'b1;
      e.q  = 8'hFF;
      e.r  = a[7:0];
    end else if (a[15:8] >= b) begin
      e.ov = 1'b1;
      e.q  = 8'hFF;
      e.r  = a[7:0];
    end else begin
      qa  = int'(a) / int'(b);
      ra  = int'(a) % int'(b);
      e.q = qa[7:0];
      e.r = ra[7:0];
    end
    return e;
  endfunction

  // Scoreboard check: a result is consumed at the edge following a negedge with valid and ready high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_result: got q=%0d r=%0d dz=%b ov=%b, required no output",
                 quotient, remainder, div_by_zero, overflow);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({quotient, remainder, div_by_zero, overflow} !== {e.q, e.r, e.dz, e.ov}) begin
          tests_failed++;
          $display("[TB] FAIL result: got q=%0d r=%0d dz=%b ov=%b, required q=%0d r=%0d dz=%b ov=%b",
                   quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dz, e.ov);
        end
      end
    end
  end

  // Present an op and hold it until accepted; returns at #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b q=%0d r=%0d dz=%b ov=%b, required rdy=1 vld=0 q=0 r=0 dz=0 ov=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [7:0] b, input int lat, input string name);
    int cyc;
    issue(a, b);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_busy: in_ready=%b, required 0", name, in_ready);
    end
    wait_valid(cyc);
    tests_run++;
    if (cyc !== lat) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: got %0d cycles, required %0d", name, cyc, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    out_ready = 1'b1;
    run_one(16'd20000, 8'd200, 8, "div_20000_200");
    run_one(16'd1000,  8'd7,   8, "div_1000_7");
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    run_one(16'h1234, 8'h00, 1, "div_by_zero");
    run_one(16'hFF00, 8'h10, 1, "overflow");
  endtask

  task automatic test_back_to_back();
    int t0;
    out_ready = 1'b1;
    issue(16'd5000, 8'd50);
    t0 = cycle_count;
    issue(16'd777, 8'd9);
    tests_run++;
    if (cycle_count - t0 !== 10) begin
      tests_failed++;
      $display("[TB] FAIL issue_interval: got %0d cycles, required 10", cycle_count - t0);
    end
    repeat (12) begin @(posedge clk); #1; end
  endtask

  task automatic test_backpressure();
    int         cyc;
    logic [7:0] sq, sr;
    logic       sdz, sov;
    out_ready = 1'b0;
    issue(16'd65279, 8'd255);
    wait_valid(cyc);
    tests_run++;
    if (cyc !== 8) begin
      tests_failed++;
      $display("[TB] FAIL bp_latency: got %0d cycles, required 8", cyc);
    end
    sq = quotient; sr = remainder; sdz = div_by_zero; sov = overflow;
    in_valid = 1'b1;
    dividend = 16'd100;
    divisor  = 8'd3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {quotient, remainder, div_by_zero, overflow} !== {sq, sr, sdz, sov}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold cycle %0d: got vld=%b rdy=%b q=%0d r=%0d, required vld=1 rdy=0 q=%0d r=%0d",
                 i, out_valid, in_ready, quotient, remainder, sq, sr);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: got vld=%b rdy=%b, required vld=0 rdy=1", out_valid, in_ready);
    end
    sb.push_back(model(16'd100, 8'd3));
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_next_accept: in_ready=%b, required 0", in_ready);
    end
    wait_valid(cyc);
    tests_run++;
    if (cyc !== 8) begin
      tests_failed++;
      $display("[TB] FAIL bp_next_latency: got %0d cycles, required 8", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midcalc();
    int seen = 0;
    out_ready = 1'b1;
    issue(16'd20000, 8'd200);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    tests_run++;
    if ({out_valid, quotient, remainder, div_by_zero, overflow, in_ready} !== {1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL midcalc_reset: got vld=%b q=%0d r=%0d dz=%b ov=%b rdy=%b, required 0 0 0 0 0 1",
               out_valid, quotient, remainder, div_by_zero, overflow, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL discarded_op: got %0d valid cycles rdy=%b, required 0 valid rdy=1", seen, in_ready);
    end
    run_one(16'd255, 8'd1, 8, "after_reset_255_1");
    run_one(16'd254, 8'd1, 8, "after_reset_254_1");
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [7:0]  hi;
    logic [15:0] a;
    int          n;
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      hi = (b > 8'd0 && (i % 4) != 0) ? 8'($urandom_range(0, int'(b) - 1)) : 8'($urandom_range(0, 255));
      a  = {hi, 8'($urandom_range(0, 255))};
      issue(a, b);
      n = 0;
      while (sb.size() != 0 && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      out_ready = 1'b1;
      tests_run++;
      if (sb.size() != 0) begin
        tests_failed++;
        $display("[TB] FAIL random_timeout op %0d: %0d results pending, required 0", i, sb.size());
        sb.delete();
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_normal();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_midcalc();
    test_random();
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d results never produced, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
